// File: rtl/keycode_ctrl.sv
// keycode_ctrl: turns a USB HID keycode into per-frame movement controls.
// The keycode is sampled once per frame (rising edge of the synchronized
// VGA vsync), debounced across frames, and mapped to left/right/jump. Run
// asserts once a direction has been held long enough, and jump fires once
// per fresh jump-key commit.
module keycode_ctrl #(
   parameter int DEBOUNCE_FRAMES = 2,
   parameter int RUN_FRAMES      = 30
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic [7:0] keycode,
   input  logic       vs,
   output logic       frame_tick,
   output logic       move_left,
   output logic       move_right,
   output logic       run,
   output logic       jump_pulse,
   output logic [7:0] hold_count
);

   typedef enum logic [1:0] {ST_IDLE, ST_LEFT, ST_RIGHT} state_t;
   typedef enum logic [1:0] {K_NONE, K_LEFT, K_RIGHT, K_JUMP} key_t;

   localparam logic [3:0] DB_CNT  = 4'(DEBOUNCE_FRAMES);
   localparam logic [7:0] RUN_CNT = 8'(RUN_FRAMES);

   // Keycode to action class; anything unrecognized behaves like no key.
   function automatic key_t classify(input logic [7:0] code);
      case (code)
         8'h04:        return K_LEFT;
         8'h07:        return K_RIGHT;
         8'h1A, 8'h2C: return K_JUMP;
         default:      return K_NONE;
      endcase
   endfunction

   logic       vs_s1, vs_s2, vs_d;
   logic [7:0] cand;
   logic [3:0] cnt;
   key_t       last_cls;
   state_t     state;

   logic       same;
   logic [3:0] cnt_n;
   logic       commit;
   key_t       cls;
   state_t     state_n;
   logic [7:0] hold_n;
   logic       jump_fire;

   // vsync synchronizer and rising-edge detect; flops idle high so a reset
   // release in the middle of a frame cannot look like an edge.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         vs_s1      <= 1'b1;
         vs_s2      <= 1'b1;
         vs_d       <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         vs_s1      <= vs;
         vs_s2      <= vs_s1;
         vs_d       <= vs_s2;
         frame_tick <= vs_s2 & ~vs_d;
      end
   end

   // Next-tick values: debounce, commit decision, direction and hold count.
   always_comb begin
      same    = (keycode == cand);
      cnt_n   = 4'd1;
      if (same) cnt_n = (cnt == 4'd15) ? 4'd15 : cnt + 4'd1;
      // A saturated count that equals the threshold must not re-commit.
      commit  = (cnt_n == DB_CNT) && !(same && cnt == DB_CNT);
      cls     = classify(keycode);
      state_n = state;
      if (commit) begin
         case (cls)
            K_LEFT:  state_n = ST_LEFT;
            K_RIGHT: state_n = ST_RIGHT;
            K_NONE:  state_n = ST_IDLE;
            default: state_n = state;
         endcase
      end
      // A state change wins over the increment on the same tick.
      if (state_n != state || state_n == ST_IDLE) hold_n = 8'd0;
      else if (hold_count == 8'hFF)               hold_n = 8'hFF;
      else                                        hold_n = hold_count + 8'd1;
      jump_fire = commit && (cls == K_JUMP) && (last_cls != K_JUMP);
   end

   // Direction FSM with registered outputs, advanced only on frame ticks.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= ST_IDLE;
         cand       <= 8'h00;
         cnt        <= 4'd0;
         last_cls   <= K_NONE;
         hold_count <= 8'd0;
         move_left  <= 1'b0;
         move_right <= 1'b0;
         run        <= 1'b0;
         jump_pulse <= 1'b0;
      end else begin
         jump_pulse <= 1'b0;
         if (frame_tick) begin
            cand       <= keycode;
            cnt        <= cnt_n;
            state      <= state_n;
            hold_count <= hold_n;
            move_left  <= (state_n == ST_LEFT);
            move_right <= (state_n == ST_RIGHT);
            run        <= (state_n != ST_IDLE) && (hold_n >= RUN_CNT);
            jump_pulse <= jump_fire;
            if (commit) last_cls <= cls;
         end
      end
   end

endmodule

// File: tb/tb_keycode_ctrl.sv
// tb_keycode_ctrl: directed frame-by-frame stimulus for keycode_ctrl with
// hand-computed expectations for the default parameters.
module tb_keycode_ctrl;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic [7:0] keycode = 8'h00;
   logic       vs = 1'b1;
   logic       frame_tick, move_left, move_right, run, jump_pulse;
   logic [7:0] hold_count;

   int n_pass = 0, n_total = 0;
   int n_ticks = 0, n_jumps = 0, n_both = 0;

   keycode_ctrl dut (
      .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .vs(vs),
      .frame_tick(frame_tick), .move_left(move_left), .move_right(move_right),
      .run(run), .jump_pulse(jump_pulse), .hold_count(hold_count)
   );

   always #10 Clk = ~Clk;

   // Event counters and the left/right exclusivity watch.
   always @(posedge Clk) begin
      if (frame_tick) n_ticks++;
      if (jump_pulse) n_jumps++;
   end
   always @(negedge Clk) if (move_left && move_right) n_both++;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   // One frame: vs low pulse then high; returns at the negedge after the
   // tick's update edge, where the outputs reflect that tick.
   task automatic tick(input logic [7:0] k);
      bit seen = 0;
      keycode = k;
      vs = 1'b0;
      repeat (4) @(negedge Clk);
      vs = 1'b1;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge Clk);
         if (frame_tick) seen = 1;
      end
      if (!seen) chk("tick_timeout", 0, 1);
      @(negedge Clk);
   endtask

   task automatic chk_outs(input string tag, input logic l, input logic r,
                           input logic rn, input logic [7:0] h);
      chk({tag, "_left"},  move_left,  l);
      chk({tag, "_right"}, move_right, r);
      chk({tag, "_run"},   run,        rn);
      chk({tag, "_hold"},  hold_count, h);
   endtask

   initial begin
      int t0, j0, bad;
      // Reset state
      repeat (3) @(negedge Clk);
      chk("rst_tick", frame_tick, 0);
      chk("rst_jump", jump_pulse, 0);
      chk_outs("rst", 0, 0, 0, 8'd0);
      Reset_n = 1'b1;
      repeat (3) @(negedge Clk);
      chk("no_tick_after_rst", n_ticks, 0);

      // D from tick 1: commit on tick 2, hold 1 on tick 3, run on tick 32
      tick(8'h07);
      chk_outs("t1", 0, 0, 0, 8'd0);
      tick(8'h07);
      chk_outs("t2", 0, 1, 0, 8'd0);
      tick(8'h07);
      chk_outs("t3", 0, 1, 0, 8'd1);
      for (int i = 4; i <= 31; i++) tick(8'h07);
      chk_outs("t31", 0, 1, 0, 8'd29);
      tick(8'h07);
      chk_outs("t32", 0, 1, 1, 8'd30);
      chk("tick_count", n_ticks, 32);
      for (int i = 33; i <= 42; i++) tick(8'h07);
      chk("t42_hold", hold_count, 8'd40);

      // Space while running right: one pulse after the 2nd Space tick
      j0 = n_jumps;
      tick(8'h2C);
      chk("sp1_jump", jump_pulse, 0);
      tick(8'h2C);
      chk("sp2_jump", jump_pulse, 1);
      chk_outs("sp2", 0, 1, 1, 8'd42);
      @(negedge Clk);
      chk("sp2_one_cycle", jump_pulse, 0);
      for (int i = 0; i < 10; i++) tick(8'h2C);
      tick(8'h1A);
      tick(8'h1A);
      tick(8'h1A);
      chk("jump_once", n_jumps - j0, 1);
      chk_outs("sp_hold", 0, 1, 1, 8'd55);

      // Reset mid-frame while running
      @(negedge Clk);
      Reset_n = 1'b0;
      #1;
      chk_outs("arst", 0, 0, 0, 8'd0);
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      t0 = n_ticks;
      repeat (10) @(negedge Clk);
      chk("arst_no_tick", n_ticks - t0, 0);
      tick(8'h07);
      chk("arst_next_tick", n_ticks - t0, 1);
      chk_outs("arst_t1", 0, 0, 0, 8'd0);
      tick(8'h07);
      chk_outs("arst_t2", 0, 1, 0, 8'd0);

      // Release to idle, then toggling A/none never commits
      tick(8'h00);
      tick(8'h00);
      chk_outs("idle", 0, 0, 0, 8'd0);
      j0 = n_jumps;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick((i % 2 == 0) ? 8'h04 : 8'h00);
         if (move_left || move_right || run || hold_count != 8'd0) bad++;
      end
      chk("toggle_no_commit", bad, 0);
      chk("toggle_no_jump", n_jumps - j0, 0);

      // Between-tick glitches 04->07->04 are never sampled
      tick(8'h04);
      bad = 0;
      keycode = 8'h07;
      repeat (2) @(negedge Clk);
      if (move_left || move_right) bad++;
      keycode = 8'h04;
      repeat (2) @(negedge Clk);
      if (move_left || move_right) bad++;
      chk("glitch_quiet", bad, 0);
      tick(8'h04);
      chk_outs("glitch_left", 1, 0, 0, 8'd0);

      // Right held long: saturation, then switch to left
      tick(8'h07);
      chk_outs("sw_r1", 1, 0, 0, 8'd1);
      tick(8'h07);
      chk_outs("sw_r2", 0, 1, 0, 8'd0);
      for (int i = 0; i < 298; i++) tick(8'h07);
      chk_outs("sat", 0, 1, 1, 8'd255);
      tick(8'h04);
      chk_outs("sat_a1", 0, 1, 1, 8'd255);
      tick(8'h04);
      chk_outs("sat_a2", 1, 0, 0, 8'd0);

      chk("never_both", n_both, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/keycode_ctrl.md
KEYCODE_CTRL -- requirements
Module: keycode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_FRAMES, default 2: consecutive frame ticks a keycode must be stable before it commits (range 1-15).
REQ-002 Parameter RUN_FRAMES, default 30: committed frames of held direction before run asserts (range 1-255).
REQ-003 Clk  input  1  system clock, 50 MHz.
REQ-004 Reset_n  input  1  reset, asynchronous, active-low.
REQ-005 keycode  input  8  USB HID keycode from the SoC PIO; 0x00 = no key.
REQ-006 vs  input  1  VGA vertical sync, active-low pulse, asynchronous to the control logic.
REQ-007 frame_tick  output  1  one-cycle pulse per frame, for downstream motion logic.
REQ-008 move_left  output  1  committed direction is left.
REQ-009 move_right  output  1  committed direction is right.
REQ-010 run  output  1  current direction held for at least RUN_FRAMES frames.
REQ-011 jump_pulse  output  1  one-cycle jump request.
REQ-012 hold_count  output  8  frames the current direction has been held, saturating.

Function
REQ-013 vs SHALL pass through a two-flop synchronizer; frame_tick SHALL be high for exactly one Clk cycle per rising edge of the synchronized vs, and never on a falling edge.
REQ-014 keycode SHALL be sampled only in a frame_tick cycle; between ticks, keycode changes SHALL have no effect.
REQ-015 Debounce: hold a candidate code and a 4-bit stability count; on a tick, sample == candidate increments the count (saturating at 15); otherwise candidate <= sample and count <= 1.
REQ-016 The candidate SHALL commit on the tick where the updated count equals DEBOUNCE_FRAMES; later ticks with an unchanged candidate SHALL NOT re-commit.
REQ-017 Key map: 0x04 (A) = LEFT; 0x07 (D) = RIGHT; 0x1A (W) and 0x2C (Space) = JUMP; every other code, including 0x00, = NONE.
REQ-018 Direction FSM states: IDLE, LEFT, RIGHT; on commit, LEFT goes to LEFT, RIGHT goes to RIGHT, NONE goes to IDLE, and JUMP leaves the state unchanged.
REQ-019 move_left = (state == LEFT) and move_right = (state == RIGHT), both registered; they SHALL never be high together.
REQ-020 hold_count SHALL clear to 0 on any state change and when entering IDLE.
REQ-021 In LEFT or RIGHT, each tick with no state change SHALL increment hold_count, saturating at 255; it SHALL also increment while a JUMP code is committed or pending.
REQ-022 run SHALL be high iff state is LEFT or RIGHT and hold_count >= RUN_FRAMES.
REQ-023 jump_pulse SHALL be high for exactly one cycle, the cycle after the tick on which a JUMP code commits, provided the previously committed code was not JUMP.
REQ-024 Holding W/Space SHALL NOT repeat jump_pulse, and switching directly between W and Space SHALL NOT re-trigger it.
REQ-025 All state, count and direction updates SHALL occur on the tick edge; the outputs SHALL be valid the cycle after frame_tick.
REQ-026 Simultaneous events: a commit and a hold_count increment on the same tick resolve as commit first; a state change clears hold_count and suppresses the increment.

Reset
REQ-027 While Reset_n = 0, asynchronously: state = IDLE; candidate = 0x00; stability count = 0; last committed code = NONE; hold_count = 0; synchronizer flops = 1; all outputs = 0.
REQ-028 Reset deassertion mid-frame SHALL NOT produce a spurious frame_tick, because the synchronizer resets to the vs idle-high level.
REQ-029 Reset asserted during any state SHALL abort that state with no jump_pulse or frame_tick emitted.

Verification
REQ-030 Defaults; vs pulses every 100 cycles; keycode = 0x07 from tick 1 onward -> move_right rises after tick 2; hold_count = 1 after tick 3; run rises after tick 32.
REQ-031 keycode toggles 0x04/0x00 on every tick -> no commit occurs; state stays IDLE and all outputs stay 0.
REQ-032 RIGHT held for 40 ticks, then keycode = 0x2C -> one jump_pulse after the 2nd Space tick; move_right stays 1; hold_count keeps counting; no further pulses during 10 more Space ticks.
REQ-033 keycode changes 0x04 -> 0x07 -> 0x04 between two ticks -> only the value present at the tick is sampled; no glitch appears on the outputs.
REQ-034 RIGHT with run = 1, then Reset_n pulsed low for 3 cycles mid-frame -> all outputs become 0 immediately; frame_tick is absent until the next vs rising edge.
REQ-035 RIGHT held for 300 ticks -> hold_count saturates at 255 and run stays 1; keycode = 0x04 -> after 2 ticks move_left = 1, move_right = 0, hold_count = 0, run = 0.
